// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of sdram_controller.
// Tracks read issuers in an in-order ID FIFO and steers responses back.
module sdram_arbiter #(
  parameter int DW     = 16,
  parameter int AW     = 24,
  parameter int MAX_RD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req_valid,
  input  logic          p0_req_write,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  input  logic [1:0]    p0_req_byteenable,
  output logic          p0_req_ready,
  output logic          p0_rsp_valid,
  output logic [DW-1:0] p0_rsp_rdata,
  input  logic          p1_req_valid,
  input  logic          p1_req_write,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  input  logic [1:0]    p1_req_byteenable,
  output logic          p1_req_ready,
  output logic          p1_rsp_valid,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          m_req_valid,
  output logic          m_req_write,
  output logic [AW-1:0] m_req_addr,
  output logic [DW-1:0] m_req_wdata,
  output logic [1:0]    m_req_byteenable,
  input  logic          m_req_ready,
  input  logic          m_rsp_valid,
  input  logic [DW-1:0] m_rsp_rdata,
  output logic          err_orphan
);

  localparam int PW = $clog2(MAX_RD);
  localparam logic [PW:0] FULL = MAX_RD[PW:0];

  logic              prio_q;
  logic              lock_q;
  logic              lock_port_q;
  logic              err_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW:0]       cnt_q;
  logic [PW:0]       cnt_d;
  logic [MAX_RD-1:0] id_q;

  logic full, empty, e0, e1;
  logic gnt, gnt_vld, acc, push, pop, head;

  always_comb begin
    full    = (cnt_q == FULL);
    empty   = (cnt_q == '0);
    e0      = p0_req_valid && (p0_req_write || !full);
    e1      = p1_req_valid && (p1_req_write || !full);
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    // A stalled request is pinned until the controller takes it
    if (lock_q) begin
      gnt     = lock_port_q;
      gnt_vld = lock_port_q ? p1_req_valid : p0_req_valid;
    end else if (prio_q ? e1 : e0) begin
      gnt     = prio_q;
      gnt_vld = 1'b1;
    end else if (prio_q ? e0 : e1) begin
      gnt     = ~prio_q;
      gnt_vld = 1'b1;
    end
    acc   = gnt_vld && m_req_ready;
    push  = acc && !m_req_write;
    pop   = m_rsp_valid && !empty;
    head  = id_q[rd_ptr_q];
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  assign m_req_valid      = gnt_vld;
  assign m_req_write      = gnt ? p1_req_write : p0_req_write;
  assign m_req_addr       = gnt ? p1_req_addr : p0_req_addr;
  assign m_req_wdata      = gnt ? p1_req_wdata : p0_req_wdata;
  assign m_req_byteenable = gnt ? p1_req_byteenable
                                : p0_req_byteenable;
  assign p0_req_ready     = gnt_vld && !gnt && m_req_ready;
  assign p1_req_ready     = gnt_vld && gnt && m_req_ready;
  assign p0_rsp_valid     = pop && !head;
  assign p1_rsp_valid     = pop && head;
  assign p0_rsp_rdata     = m_rsp_rdata;
  assign p1_rsp_rdata     = m_rsp_rdata;
  assign err_orphan       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= 1'b0;
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
      err_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
    end else begin
      if (gnt_vld && !m_req_ready) begin
        lock_q      <= 1'b1;
        lock_port_q <= gnt;
      end
      if (acc) begin
        lock_q <= 1'b0;
        prio_q <= ~gnt;
      end
      if (push) begin
        id_q[wr_ptr_q] <= gnt;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (m_rsp_valid && empty) err_q <= 1'b1;
    end
  end

endmodule
